// File: rtl/scan_scheduler_pkg.sv
// rtl/scan_scheduler_pkg.sv - shared state encoding and per-scale limit helpers for scan_scheduler
package scan_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_EXIT,
        S_EXIT_GUARD,
        S_EXIT_WAIT
    } states_t;

    localparam int PERF_W = 32;

    // Largest legal window origin along one axis at scale s; negative means the window no longer fits.
    function automatic int scale_limit(input int dim, input int win, input int s);
        return (dim >> s) - win;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_coord_gen.sv
// rtl/scan_coord_gen.sv - x/y/scale position counters with per-scale limit compare
module scan_coord_gen
    import scan_scheduler_pkg::*;
#(
    parameter int CORES    = 4,
    parameter int IMG_COLS = 320,
    parameter int IMG_ROWS = 240,
    parameter int WIN      = 24,
    parameter int SCALES   = 4,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int S_W      = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [S_W-1:0] s,
    output logic           last,
    output logic           valid_next_scale,
    output logic           scale0_valid
);

    localparam int LIM_W = max_int(X_W, Y_W) + 1;

    logic [X_W-1:0]          x_q, x_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic [S_W-1:0]          s_q, s_d;
    logic signed [LIM_W-1:0] x_max, y_max, x_max_nxt, y_max_nxt;
    logic signed [LIM_W:0]   x_step;
    logic                    x_fits, y_fits, next_ok;

    always_comb begin
        x_max     = LIM_W'(scale_limit(IMG_COLS, WIN, int'(s_q)));
        y_max     = LIM_W'(scale_limit(IMG_ROWS, WIN, int'(s_q)));
        x_max_nxt = LIM_W'(scale_limit(IMG_COLS, WIN, int'(s_q) + 1));
        y_max_nxt = LIM_W'(scale_limit(IMG_ROWS, WIN, int'(s_q) + 1));
        // One extra bit so x + CORES past the row end still compares correctly.
        x_step    = $signed((LIM_W+1)'(x_q) + (LIM_W+1)'(CORES));
        x_fits    = x_step <= $signed({x_max[LIM_W-1], x_max});
        y_fits    = $signed(LIM_W'(y_q)) < y_max;
        next_ok   = (int'(s_q) + 1 < SCALES) && !x_max_nxt[LIM_W-1] && !y_max_nxt[LIM_W-1];

        x_d = x_q;
        y_d = y_q;
        s_d = s_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
            s_d = '0;
        end else if (advance) begin
            if (x_fits) begin
                x_d = x_q + X_W'(CORES);
            end else if (y_fits) begin
                x_d = '0;
                y_d = y_q + Y_W'(1);
            end else if (next_ok) begin
                x_d = '0;
                y_d = '0;
                s_d = s_q + S_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            s_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            s_q <= s_d;
        end
    end

    assign x                = x_q;
    assign y                = y_q;
    assign s                = s_q;
    assign valid_next_scale = next_ok;
    assign last             = !x_fits && !y_fits && !next_ok;
    assign scale0_valid     = (scale_limit(IMG_COLS, WIN, 0) >= 0) && (scale_limit(IMG_ROWS, WIN, 0) >= 0);

endmodule

// File: rtl/scan_scheduler.sv
// rtl/scan_scheduler.sv - frame scan sequencer issuing batch start/exit commands to the result store
// Optional build macro SCAN_PERF_COUNTERS_EN adds perf_cycles / perf_stall counters.
module scan_scheduler
    import scan_scheduler_pkg::*;
#(
    parameter int CORES    = 4,
    parameter int IMG_COLS = 320,
    parameter int IMG_ROWS = 240,
    parameter int WIN      = 24,
    parameter int SCALES   = 4,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int S_W      = 3,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_go,
    input  logic             scan_abort,
    output logic             scan_busy,
    output logic             scan_done,
    output logic [CNT_W-1:0] batch_count,
    input  logic             rs_ready,
    output logic             rs_start,
    output logic             rs_exit,
    output logic [X_W-1:0]   rs_start_x,
    output logic [Y_W-1:0]   rs_start_y,
    output logic [S_W-1:0]   rs_scale
`ifdef SCAN_PERF_COUNTERS_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    states_t          state_q, state_d;
    logic             start_q, start_d;
    logic             exit_q, exit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             coord_clear, coord_advance;
    logic             coord_last, coord_next_scale, coord_scale0_valid;

    scan_coord_gen #(
        .CORES   (CORES),
        .IMG_COLS(IMG_COLS),
        .IMG_ROWS(IMG_ROWS),
        .WIN     (WIN),
        .SCALES  (SCALES),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .S_W     (S_W)
    ) u_coord (
        .clk             (clk),
        .reset           (reset),
        .clear           (coord_clear),
        .advance         (coord_advance),
        .x               (rs_start_x),
        .y               (rs_start_y),
        .s               (rs_scale),
        .last            (coord_last),
        .valid_next_scale(coord_next_scale),
        .scale0_valid    (coord_scale0_valid)
    );

    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        exit_d        = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        count_d       = count_q;
        coord_clear   = 1'b0;
        coord_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_go) begin
                    coord_clear = 1'b1;
                    count_d     = '0;
                    busy_d      = 1'b1;
                    state_d     = coord_scale0_valid ? S_ISSUE : S_EXIT;
                end
            end
            S_ISSUE: begin
                if (rs_ready) begin
                    start_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    state_d = S_GUARD;
                end
            end
            // The store's ready drop is registered, so ready is still stale during the start cycle.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (rs_ready) begin
                    if (scan_abort || coord_last) begin
                        state_d = S_EXIT;
                    end else begin
                        coord_advance = 1'b1;
                        state_d       = S_ISSUE;
                    end
                end
            end
            S_EXIT: begin
                if (rs_ready) begin
                    start_d = 1'b1;
                    exit_d  = 1'b1;
                    state_d = S_EXIT_GUARD;
                end
            end
            S_EXIT_GUARD: state_d = S_EXIT_WAIT;
            S_EXIT_WAIT: begin
                if (rs_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            exit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            exit_q  <= exit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign rs_start    = start_q;
    assign rs_exit     = exit_q;
    assign scan_busy   = busy_q;
    assign scan_done   = done_q;
    assign batch_count = count_q;

`ifdef SCAN_PERF_COUNTERS_EN
    logic [PERF_W-1:0] perf_cycles_q, perf_cycles_d;
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic              stalled;

    always_comb begin
        stalled       = ((state_q == S_ISSUE) || (state_q == S_EXIT)) && !rs_ready;
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if ((state_q == S_IDLE) && scan_go) begin
            perf_cycles_d = '0;
            perf_stall_d  = '0;
        end else begin
            if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + PERF_W'(1);
            if (stalled && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_scan_scheduler.sv
// tb/tb_scan_scheduler.sv - scoreboard bench for scan_scheduler (default, 32x24 and 16x16 frames)
module tb_scan_scheduler;

    typedef struct {
        bit ex;
        int x;
        int y;
        int s;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] go, abort, rdy, start, ex, busy, done;
    logic [19:0] bc [3];
    logic [8:0]  sx [3];
    logic [8:0]  sy [3];
    logic [2:0]  ss [3];
`ifdef SCAN_PERF_COUNTERS_EN
    logic [31:0] pc [3];
    logic [31:0] ps [3];
`endif

    exp_t exp_q[$];
    int   cur;
    int   n_cmp, n_bad;
    int   starts [3];
    int   dones [3];
    int   low_cnt [3];
    bit   pend [3];
    bit   hold [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    scan_scheduler dut0 (
        .clk(clk), .reset(rst), .scan_go(go[0]), .scan_abort(abort[0]),
        .scan_busy(busy[0]), .scan_done(done[0]), .batch_count(bc[0]),
        .rs_ready(rdy[0]), .rs_start(start[0]), .rs_exit(ex[0]),
        .rs_start_x(sx[0]), .rs_start_y(sy[0]), .rs_scale(ss[0])
`ifdef SCAN_PERF_COUNTERS_EN
        , .perf_cycles(pc[0]), .perf_stall(ps[0])
`endif
    );

    scan_scheduler #(.IMG_COLS(32), .IMG_ROWS(24), .SCALES(2)) dut1 (
        .clk(clk), .reset(rst), .scan_go(go[1]), .scan_abort(abort[1]),
        .scan_busy(busy[1]), .scan_done(done[1]), .batch_count(bc[1]),
        .rs_ready(rdy[1]), .rs_start(start[1]), .rs_exit(ex[1]),
        .rs_start_x(sx[1]), .rs_start_y(sy[1]), .rs_scale(ss[1])
`ifdef SCAN_PERF_COUNTERS_EN
        , .perf_cycles(pc[1]), .perf_stall(ps[1])
`endif
    );

    scan_scheduler #(.IMG_COLS(16), .IMG_ROWS(16)) dut2 (
        .clk(clk), .reset(rst), .scan_go(go[2]), .scan_abort(abort[2]),
        .scan_busy(busy[2]), .scan_done(done[2]), .batch_count(bc[2]),
        .rs_ready(rdy[2]), .rs_start(start[2]), .rs_exit(ex[2]),
        .rs_start_x(sx[2]), .rs_start_y(sy[2]), .rs_scale(ss[2])
`ifdef SCAN_PERF_COUNTERS_EN
        , .perf_cycles(pc[2]), .perf_stall(ps[2])
`endif
    );

    // Result-store stand-in: ready drops the cycle after a start and stays low two cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (start[i]) begin
                starts[i]++;
                n_cmp++;
                if (!rdy[i]) begin
                    n_bad++;
                    $display("FAIL start_while_not_ready dut%0d: rs_start=1 with rs_ready=0", i);
                end
                n_cmp++;
                if (i != cur) begin
                    n_bad++;
                    $display("FAIL stray_start dut%0d: start seen, only dut%0d active", i, cur);
                end else if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_start dut%0d: got exit=%0b (%0d,%0d,%0d), expected none",
                             i, ex[i], sx[i], sy[i], ss[i]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (ex[i] !== e.ex ||
                        (!e.ex && (sx[i] !== 9'(e.x) || sy[i] !== 9'(e.y) || ss[i] !== 3'(e.s)))) begin
                        n_bad++;
                        $display("FAIL batch dut%0d: got exit=%0b (%0d,%0d,%0d), expected exit=%0b (%0d,%0d,%0d)",
                                 i, ex[i], sx[i], sy[i], ss[i], e.ex, e.x, e.y, e.s);
                    end
                end
            end
            if (done[i]) dones[i]++;
            if (rst) begin
                pend[i]    = 1'b0;
                low_cnt[i] = 0;
                rdy[i]     = !hold[i];
            end else begin
                if (pend[i]) begin
                    low_cnt[i] = 2;
                    pend[i]    = 1'b0;
                end
                rdy[i] = !(hold[i] || low_cnt[i] > 0);
                if (low_cnt[i] > 0) low_cnt[i]--;
                if (start[i]) pend[i] = 1'b1;
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // Reference scan order: up to `limit` data batches, then one exit command.
    task automatic push_scan(input int cols, input int rows, input int win, input int scales, input int limit);
        int n;
        int xm, ym;
        exp_t e;
        n = 0;
        for (int s = 0; s < scales; s++) begin
            xm = (cols >> s) - win;
            ym = (rows >> s) - win;
            if (xm < 0 || ym < 0) break;
            for (int y = 0; y <= ym; y++) begin
                for (int x = 0; x <= xm; x += 4) begin
                    if (n < limit) begin
                        e = '{ex: 1'b0, x: x, y: y, s: s};
                        exp_q.push_back(e);
                    end
                    n++;
                end
            end
        end
        e = '{ex: 1'b1, x: 0, y: 0, s: 0};
        exp_q.push_back(e);
    endtask

    task automatic pulse_go(input int i);
        sync();
        go[i] = 1'b1;
        sync();
        go[i] = 1'b0;
    endtask

    task automatic wait_starts(input int i, input int target);
        int guard;
        guard = 0;
        while (starts[i] < target && guard < 5000) begin
            sync();
            guard++;
        end
        n_cmp++;
        if (starts[i] < target) begin
            n_bad++;
            $display("FAIL wait_starts dut%0d: got %0d starts, required %0d", i, starts[i], target);
        end
    endtask

    task automatic wait_done(input int i, input int target);
        int guard;
        guard = 0;
        while (dones[i] < target && guard < 5000) begin
            sync();
            guard++;
        end
        n_cmp++;
        if (dones[i] < target) begin
            n_bad++;
            $display("FAIL wait_done dut%0d: got %0d done pulses, required %0d", i, dones[i], target);
        end
    endtask

    task automatic abort_after(input int i, input int n);
        int t0, d0;
        t0 = starts[i];
        d0 = dones[i];
        wait_starts(i, t0 + n);
        abort[i] = 1'b1;
        wait_done(i, d0 + 1);
        abort[i] = 1'b0;
    endtask

    task automatic test_reset();
        sync();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({start[i], ex[i], busy[i], done[i], bc[i], sx[i], sy[i], ss[i]} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got start=%0b exit=%0b busy=%0b done=%0b count=%0d xys=(%0d,%0d,%0d), required all 0",
                         i, start[i], ex[i], busy[i], done[i], bc[i], sx[i], sy[i], ss[i]);
            end
`ifdef SCAN_PERF_COUNTERS_EN
            n_cmp++;
            if (pc[i] !== 32'd0 || ps[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_perf dut%0d: got cycles=%0d stall=%0d, required 0", i, pc[i], ps[i]);
            end
`endif
        end
        rst = 1'b0;
        repeat (3) sync();
        n_cmp++;
        if (busy !== 3'b000 || start !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b start=%b, required 000/000", busy, start);
        end
    endtask

    task automatic test_first_rows();
        int d0;
        cur = 0;
        d0  = dones[0];
        push_scan(320, 240, 24, 4, 80);
        pulse_go(0);
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_go: got %0b, required 1", busy[0]);
        end
        abort_after(0, 80);
        n_cmp++;
        if (bc[0] !== 20'd80 || busy[0] !== 1'b0 || exp_q.size() != 0 || dones[0] != d0 + 1) begin
            n_bad++;
            $display("FAIL first_rows_end: got count=%0d busy=%0b left=%0d dones=%0d, required 80/0/0/%0d",
                     bc[0], busy[0], exp_q.size(), dones[0], d0 + 1);
        end
    endtask

    task automatic test_abort();
        cur = 0;
        push_scan(320, 240, 24, 4, 5);
        pulse_go(0);
        abort_after(0, 5);
        repeat (10) sync();
        n_cmp++;
        if (bc[0] !== 20'd5 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_count: got count=%0d left=%0d, required 5/0", bc[0], exp_q.size());
        end
    endtask

    task automatic test_small_frame();
        int d0;
        cur = 1;
        d0  = dones[1];
        push_scan(32, 24, 24, 2, 1000);
        pulse_go(1);
        wait_done(1, d0 + 1);
        repeat (10) sync();
        n_cmp++;
        if (bc[1] !== 20'd3 || dones[1] != d0 + 1 || exp_q.size() != 0 || busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL small_frame: got count=%0d dones=%0d left=%0d busy=%0b, required 3/%0d/0/0",
                     bc[1], dones[1], exp_q.size(), busy[1], d0 + 1);
        end
    endtask

    task automatic test_tiny_frame();
        int d0;
        cur = 2;
        d0  = dones[2];
        push_scan(16, 16, 24, 4, 1000);
        pulse_go(2);
        wait_done(2, d0 + 1);
        repeat (5) sync();
        n_cmp++;
        if (bc[2] !== 20'd0 || dones[2] != d0 + 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL tiny_frame: got count=%0d dones=%0d left=%0d, required 0/%0d/0",
                     bc[2], dones[2], exp_q.size(), d0 + 1);
        end
    endtask

    task automatic test_stall();
        int s0;
`ifdef SCAN_PERF_COUNTERS_EN
        logic [31:0] p0, c0;
`endif
        cur     = 0;
        hold[0] = 1'b1;
        push_scan(320, 240, 24, 4, 1);
        pulse_go(0);
        sync();
        sync();
        s0 = starts[0];
`ifdef SCAN_PERF_COUNTERS_EN
        p0 = ps[0];
        c0 = pc[0];
`endif
        repeat (50) sync();
        n_cmp++;
        if (starts[0] != s0 || busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_no_start: got %0d starts busy=%0b, required %0d starts busy=1",
                     starts[0], busy[0], s0);
        end
`ifdef SCAN_PERF_COUNTERS_EN
        n_cmp++;
        if (ps[0] - p0 !== 32'd50 || pc[0] - c0 !== 32'd50) begin
            n_bad++;
            $display("FAIL perf_stall_delta: got stall+%0d cycles+%0d, required 50/50", ps[0] - p0, pc[0] - c0);
        end
`endif
        hold[0] = 1'b0;
        abort_after(0, 1);
        n_cmp++;
        if (bc[0] !== 20'd1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_end: got count=%0d left=%0d, required 1/0", bc[0], exp_q.size());
        end
    endtask

    task automatic test_reset_mid_scan();
        int t0;
        cur = 0;
        t0  = starts[0];
        push_scan(320, 240, 24, 4, 3);
        void'(exp_q.pop_back());
        pulse_go(0);
        wait_starts(0, t0 + 3);
        sync();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({start[0], ex[0], busy[0], done[0], bc[0], sx[0], sy[0], ss[0]} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got start=%0b exit=%0b busy=%0b done=%0b count=%0d xys=(%0d,%0d,%0d), required all 0",
                     start[0], ex[0], busy[0], done[0], bc[0], sx[0], sy[0], ss[0]);
        end
        sync();
        rst = 1'b0;
        sync();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_scoreboard: got %0d pending, required 0", exp_q.size());
        end
        push_scan(320, 240, 24, 4, 2);
        pulse_go(0);
        abort_after(0, 2);
        n_cmp++;
        if (bc[0] !== 20'd2 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL restart_after_reset: got count=%0d left=%0d, required 2/0", bc[0], exp_q.size());
        end
    endtask

    initial begin
        rst   = 1'b1;
        go    = '0;
        abort = '0;
        rdy   = '1;
        cur   = 0;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 3; i++) begin
            starts[i]  = 0;
            dones[i]   = 0;
            low_cnt[i] = 0;
            pend[i]    = 1'b0;
            hold[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_first_rows();
        test_abort();
        test_small_frame();
        test_tiny_frame();
        test_stall();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
